// File: rtl/rshift_pkg.sv
// Shared types and defaults for the iterative right shifter (rshift_seq).
package rshift_pkg;

  localparam int DATA_W_DEF = 28;
  localparam int STEP_DEF   = 2;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } rshift_state_t;

  // Number of clocks a clamped shift amount spends in SHIFT.
  function automatic int unsigned shift_cycles(input int unsigned amt, input int unsigned step);
    return (amt + step - 1) / step;
  endfunction

endpackage

// File: rtl/rshift_seq_if.sv
// Request/response handshake bundle for rshift_seq; in_arith exists only with RSHIFT_SEQ_ARITH_EN.
interface rshift_seq_if
  import rshift_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int AMT_W  = $clog2(DATA_W + 1)
) ();

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [AMT_W-1:0]  in_amt;
`ifdef RSHIFT_SEQ_ARITH_EN
  logic              in_arith;
`endif
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid,
    input  in_ready,
    output in_data,
    output in_amt,
`ifdef RSHIFT_SEQ_ARITH_EN
    output in_arith,
`endif
    input  out_valid,
    output out_ready,
    input  out_data
  );

  modport slave (
    input  in_valid,
    output in_ready,
    input  in_data,
    input  in_amt,
`ifdef RSHIFT_SEQ_ARITH_EN
    input  in_arith,
`endif
    output out_valid,
    input  out_ready,
    output out_data
  );

endinterface

// File: rtl/rshift_step.sv
// Combinational single-step right shifter: shifts by k (0..STEP) and fills vacated MSBs with fill.
module rshift_step #(
  parameter int DATA_W = 28,
  parameter int STEP   = 2,
  parameter int K_W    = $clog2(STEP + 1)
) (
  input  logic [DATA_W-1:0] data_in,
  input  logic [K_W-1:0]    k,
  input  logic              fill,
  output logic [DATA_W-1:0] data_out
);

  logic [DATA_W-1:0] fill_mask;

  // Ones exactly in the k vacated MSB positions.
  assign fill_mask = ~({DATA_W{1'b1}} >> k);
  assign data_out  = (data_in >> k) | (fill ? fill_mask : '0);

endmodule

// File: rtl/rshift_seq.sv
// Iterative right shifter: up to STEP bits per clock over valid/ready handshakes.
// Define RSHIFT_SEQ_ARITH_EN to add the in_arith port for arithmetic (sign-filling) shifts.
module rshift_seq
  import rshift_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int STEP   = STEP_DEF,
  localparam int AMT_W  = $clog2(DATA_W + 1),
  localparam int K_W    = $clog2(STEP + 1)
) (
  input logic        clk,
  input logic        reset,
  rshift_seq_if.slave bus
);

  if (STEP < 1 || STEP > DATA_W) begin : g_bad_step
    $error("rshift_seq: STEP must lie in 1..DATA_W");
  end

  rshift_state_t     state_q, state_d;
  logic [DATA_W-1:0] data_q;
  logic [AMT_W-1:0]  rem_q;
  logic              fill_q;

  logic [AMT_W-1:0]  amt_clamped;
  logic [AMT_W-1:0]  rem_next;
  logic [K_W-1:0]    k;
  logic [DATA_W-1:0] shifted;
  logic              fill_in;

  assign amt_clamped = (bus.in_amt > AMT_W'(DATA_W)) ? AMT_W'(DATA_W) : bus.in_amt;
  assign k           = (rem_q < AMT_W'(STEP)) ? K_W'(rem_q) : K_W'(STEP);
  assign rem_next    = rem_q - AMT_W'(k);

`ifdef RSHIFT_SEQ_ARITH_EN
  assign fill_in = bus.in_arith & bus.in_data[DATA_W-1];
`else
  assign fill_in = 1'b0;
`endif

  rshift_step #(
    .DATA_W (DATA_W),
    .STEP   (STEP),
    .K_W    (K_W)
  ) u_step (
    .data_in  (data_q),
    .k        (k),
    .fill     (fill_q),
    .data_out (shifted)
  );

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: state_d is defaulted first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.in_valid) state_d = (amt_clamped == '0) ? DONE : SHIFT;
      SHIFT:   if (rem_next == '0) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
      rem_q  <= '0;
      fill_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (bus.in_valid) begin
          data_q <= bus.in_data;
          rem_q  <= amt_clamped;
          fill_q <= fill_in;
        end
        SHIFT: begin
          data_q <= shifted;
          rem_q  <= rem_next;
        end
        default: ;
      endcase
    end
  end

  // in_ready is combinational so a request is refused during the reset cycle itself.
  assign bus.in_ready  = (state_q == IDLE) && !reset;
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_data  = data_q;

endmodule

// File: tb/tb_rshift_seq.sv
// Self-checking bench for rshift_seq: directed cases plus randomized traffic against a reference model.
module tb_rshift_seq;
  import rshift_pkg::*;

  localparam int DATA_W = 28;
  localparam int STEP   = 2;
  localparam int AMT_W  = 5;
  localparam int MAX_WAIT = 200;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  rshift_seq_if #(.DATA_W(DATA_W), .AMT_W(AMT_W)) bus ();

  rshift_seq #(.DATA_W(DATA_W), .STEP(STEP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: shift as a whole-word operation on a clamped amount.
  function automatic logic [DATA_W-1:0] ref_shift(input logic [DATA_W-1:0] d, input int amt, input bit arith);
    logic signed [DATA_W-1:0] s;
    int a;
    a = (amt > DATA_W) ? DATA_W : amt;
    s = d;
    if (arith) return DATA_W'(s >>> a);
    return (a >= DATA_W) ? '0 : d >> a;
  endfunction

  function automatic int ref_latency(input int amt);
    int a;
    a = (amt > DATA_W) ? DATA_W : amt;
    return 1 + (a + STEP - 1) / STEP;
  endfunction

  task automatic drive_arith(input bit arith);
`ifdef RSHIFT_SEQ_ARITH_EN
    bus.in_arith = arith;
`else
    if (arith) $display("note: arithmetic request ignored in logical-only build");
`endif
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic run_txn(input string tag, input logic [DATA_W-1:0] d, input int amt,
                         input bit arith, input int hold);
    logic [DATA_W-1:0] exp_data;
    int cycles;
`ifdef RSHIFT_SEQ_ARITH_EN
    exp_data = ref_shift(d, amt, arith);
`else
    exp_data = ref_shift(d, amt, 1'b0);
`endif
    check({tag, ":ready_idle"}, 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_amt   = AMT_W'(amt);
    drive_arith(arith);
    @(negedge clk);
    cycles = 1;
    // Scramble inputs after accept; the DUT must have latched them already.
    bus.in_data = DATA_W'($urandom);
    bus.in_amt  = AMT_W'($urandom);
    drive_arith(1'($urandom));
    while (!bus.out_valid && cycles < MAX_WAIT) begin
      check({tag, ":ready_busy"}, 64'(bus.in_ready), 64'd0);
      bus.in_valid = 1'($urandom);
      @(negedge clk);
      cycles++;
    end
    check({tag, ":latency"}, 64'(cycles), 64'(ref_latency(amt)));
    check({tag, ":data"}, 64'(bus.out_data), 64'(exp_data));
    for (int i = 0; i < hold; i++) begin
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'($urandom);
      @(negedge clk);
      check({tag, ":hold_valid"}, 64'(bus.out_valid), 64'd1);
      check({tag, ":hold_data"}, 64'(bus.out_data), 64'(exp_data));
      check({tag, ":hold_ready"}, 64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, ":valid_drop"}, 64'(bus.out_valid), 64'd0);
    check({tag, ":ready_back"}, 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_amt    = '0;
    bus.out_ready = 1'b0;
    drive_arith(1'b0);
    repeat (3) @(negedge clk);
    check("rst:in_ready", 64'(bus.in_ready), 64'd0);
    check("rst:out_valid", 64'(bus.out_valid), 64'd0);
    check("rst:out_data", 64'(bus.out_data), 64'd0);
    reset = 1'b0;
    #1;
    check("rst:ready_release", 64'(bus.in_ready), 64'd1);
    @(negedge clk);

    run_txn("t1", 28'h0ABCDEC, 2, 1'b0, 0);
    check("t1:ref", 64'(ref_shift(28'h0ABCDEC, 2, 1'b0)), 64'h02AF37B);
    run_txn("t2", 28'h1234567, 0, 1'b0, 0);
    run_txn("t3", 28'h8000000, 27, 1'b0, 0);
    run_txn("t4", 28'hFFFFFFF, 31, 1'b0, 1);
    run_txn("t5", 28'h5A5A5A5, 7, 1'b0, 5);

    // Reset pulse in the middle of a long shift.
    bus.in_valid = 1'b1;
    bus.in_data  = 28'hDEADBEE;
    bus.in_amt   = AMT_W'(20);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("t6:out_valid", 64'(bus.out_valid), 64'd0);
    check("t6:out_data", 64'(bus.out_data), 64'd0);
    check("t6:in_ready_rst", 64'(bus.in_ready), 64'd0);
    reset = 1'b0;
    #1;
    check("t6:in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    run_txn("t6b", 28'h0F0F0F0, 5, 1'b0, 0);

`ifdef RSHIFT_SEQ_ARITH_EN
    run_txn("arith4", 28'h8000000, 4, 1'b1, 0);
    check("arith4:ref", 64'(ref_shift(28'h8000000, 4, 1'b1)), 64'hF800000);
    run_txn("arith_clamp", 28'h8000001, 30, 1'b1, 0);
    run_txn("arith_pos", 28'h4000000, 9, 1'b1, 0);
`endif

    for (int n = 0; n < 40; n++) begin
      run_txn("rnd", DATA_W'($urandom), int'($urandom_range(0, 31)),
              1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
